// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares the single data_ram port between the openmips CPU
// data port and a DMA/loader master. One master is granted per cycle with zero
// latency. DMA bursts are bounded by DMA_MAX_BURST while the CPU waits, and the
// DMA wins after DMA_MAX_WAIT cycles of waiting. data_ram reads combinationally.
// Optional feature macro: ARB_STAT_EN adds saturating 32-bit stall counters
// (cpu_stall_cnt_o, dma_stall_cnt_o); arbitration is identical either way.
module data_ram_arbiter #(
    parameter int DW            = 32,
    parameter int AW            = 32,
    parameter int DMA_MAX_BURST = 4,
    parameter int DMA_MAX_WAIT  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_ce_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [3:0]    cpu_sel_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_stall_o,
    input  logic          dma_req_i,
    input  logic          dma_we_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [3:0]    dma_sel_i,
    input  logic [DW-1:0] dma_wdata_i,
    output logic          dma_gnt_o,
    output logic [DW-1:0] dma_rdata_o,
    output logic          dma_rvld_o,
    output logic          ram_ce_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [3:0]    ram_sel_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i
`ifdef ARB_STAT_EN
    ,
    output logic [31:0]   cpu_stall_cnt_o,
    output logic [31:0]   dma_stall_cnt_o
`endif
);

    localparam int BW = $clog2(DMA_MAX_BURST + 1);
    localparam int WW = $clog2(DMA_MAX_WAIT + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(DMA_MAX_BURST);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(DMA_MAX_WAIT);
    localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    owner_t        last_owner_r;
    owner_t        next_owner_s;
    logic [BW-1:0] burst_cnt_r;
    logic [WW-1:0] wait_cnt_r;
    logic          grant_cpu_s;
    logic          grant_dma_s;
    logic [DW-1:0] dma_rdata_r;
    logic          dma_rvld_r;

    // Grant decision: zero latency, forced off while reset is asserted.
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_dma_s = 1'b0;
        if (rst) begin
            grant_cpu_s = 1'b0;
            grant_dma_s = 1'b0;
        end else if (cpu_ce_i && dma_req_i) begin
            if (last_owner_r == OWN_DMA) begin
                // An ongoing burst continues until it reaches its cap.
                if (burst_cnt_r < BURST_MAX) begin
                    grant_dma_s = 1'b1;
                end else begin
                    grant_cpu_s = 1'b1;
                end
            end else begin
                // The CPU keeps priority until the DMA has waited long enough.
                if (wait_cnt_r == WAIT_MAX) begin
                    grant_dma_s = 1'b1;
                end else begin
                    grant_cpu_s = 1'b1;
                end
            end
        end else if (cpu_ce_i) begin
            grant_cpu_s = 1'b1;
        end else if (dma_req_i) begin
            grant_dma_s = 1'b1;
        end else begin
            grant_cpu_s = 1'b0;
            grant_dma_s = 1'b0;
        end
    end

    // Next owner follows whoever was granted this cycle.
    always_comb begin
        next_owner_s = OWN_IDLE;
        if (grant_dma_s) begin
            next_owner_s = OWN_DMA;
        end else if (grant_cpu_s) begin
            next_owner_s = OWN_CPU;
        end else begin
            next_owner_s = OWN_IDLE;
        end
    end

    // RAM port mux: granted master's fields, all zero when nobody is granted.
    always_comb begin
        ram_ce_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = {AW{1'b0}};
        ram_sel_o   = 4'b0000;
        ram_wdata_o = {DW{1'b0}};
        case ({grant_dma_s, grant_cpu_s})
            2'b01: begin
                ram_ce_o    = 1'b1;
                ram_we_o    = cpu_we_i;
                ram_addr_o  = cpu_addr_i;
                ram_sel_o   = cpu_sel_i;
                ram_wdata_o = cpu_wdata_i;
            end
            2'b10: begin
                ram_ce_o    = 1'b1;
                ram_we_o    = dma_we_i;
                ram_addr_o  = dma_addr_i;
                ram_sel_o   = dma_sel_i;
                ram_wdata_o = dma_wdata_i;
            end
            default: begin
                ram_ce_o    = 1'b0;
                ram_we_o    = 1'b0;
                ram_addr_o  = {AW{1'b0}};
                ram_sel_o   = 4'b0000;
                ram_wdata_o = {DW{1'b0}};
            end
        endcase
    end

    assign cpu_rdata_o = ram_rdata_i;
    assign cpu_stall_o = ~rst & cpu_ce_i & ~grant_cpu_s;
    assign dma_gnt_o   = grant_dma_s;
    assign dma_rdata_o = dma_rdata_r;
    assign dma_rvld_o  = dma_rvld_r;

    // Owner history plus burst and wait counters that bound DMA fairness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_r <= OWN_IDLE;
            burst_cnt_r  <= {BW{1'b0}};
            wait_cnt_r   <= {WW{1'b0}};
        end else begin
            last_owner_r <= next_owner_s;
            if (grant_dma_s) begin
                if (burst_cnt_r < BURST_MAX) begin
                    burst_cnt_r <= burst_cnt_r + BURST_ONE;
                end else begin
                    burst_cnt_r <= burst_cnt_r;
                end
            end else begin
                burst_cnt_r <= {BW{1'b0}};
            end
            if (grant_dma_s || !dma_req_i) begin
                wait_cnt_r <= {WW{1'b0}};
            end else if (wait_cnt_r < WAIT_MAX) begin
                wait_cnt_r <= wait_cnt_r + WAIT_ONE;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Capture DMA read data and pulse its valid the cycle after the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dma_rdata_r <= {DW{1'b0}};
            dma_rvld_r  <= 1'b0;
        end else if (grant_dma_s && !dma_we_i) begin
            dma_rdata_r <= ram_rdata_i;
            dma_rvld_r  <= 1'b1;
        end else begin
            dma_rdata_r <= dma_rdata_r;
            dma_rvld_r  <= 1'b0;
        end
    end

`ifdef ARB_STAT_EN
    logic [31:0] cpu_stall_cnt_r;
    logic [31:0] dma_stall_cnt_r;

    // Saturating stall statistics for both masters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_stall_cnt_r <= 32'h0000_0000;
            dma_stall_cnt_r <= 32'h0000_0000;
        end else begin
            if (cpu_stall_o && (cpu_stall_cnt_r != 32'hFFFF_FFFF)) begin
                cpu_stall_cnt_r <= cpu_stall_cnt_r + 32'h0000_0001;
            end else begin
                cpu_stall_cnt_r <= cpu_stall_cnt_r;
            end
            if (dma_req_i && !grant_dma_s && (dma_stall_cnt_r != 32'hFFFF_FFFF)) begin
                dma_stall_cnt_r <= dma_stall_cnt_r + 32'h0000_0001;
            end else begin
                dma_stall_cnt_r <= dma_stall_cnt_r;
            end
        end
    end

    assign cpu_stall_cnt_o = cpu_stall_cnt_r;
    assign dma_stall_cnt_o = dma_stall_cnt_r;
`endif

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: scoreboard bench for data_ram_arbiter with a small
// data_ram fixture. Expected grants and DMA read data are queued when stimulus
// is driven and popped when the DUT outputs are sampled.
module tb_data_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_ce, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_sel;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [3:0]  dma_sel;
    logic        dma_gnt, dma_rvld;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;
`ifdef ARB_STAT_EN
    logic [31:0] cpu_stall_cnt, dma_stall_cnt;
`endif

    data_ram_arbiter #(.DW(32), .AW(32), .DMA_MAX_BURST(4), .DMA_MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_ce_i(cpu_ce), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_sel_i(cpu_sel), .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata),
        .cpu_stall_o(cpu_stall),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
        .dma_sel_i(dma_sel), .dma_wdata_i(dma_wdata), .dma_gnt_o(dma_gnt),
        .dma_rdata_o(dma_rdata), .dma_rvld_o(dma_rvld),
        .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_sel_o(ram_sel), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
`ifdef ARB_STAT_EN
        , .cpu_stall_cnt_o(cpu_stall_cnt), .dma_stall_cnt_o(dma_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_ram fixture: combinational read, byte-enabled write on the edge.
    logic [31:0] mem [0:63];
    logic        init_mem;
    assign ram_rdata = mem[ram_addr[7:2]];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (ram_ce && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem[ram_addr[7:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
    end

    typedef struct packed {
        logic gcpu;
        logic gdma;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] exp_mem [0:63];
    int          m_last, m_burst, m_wait;
    logic        exp_rvld;
    logic        dma_pend;
    int          n_checks, n_fail;
    int          cnt_cpu_g, cnt_dma_g;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last   = 0;
        m_burst  = 0;
        m_wait   = 0;
        exp_rvld = 1'b0;
        dma_pend = 1'b0;
        exp_q.delete();
        rd_q.delete();
    endtask

    // One arbitration cycle: inputs already set at posedge+1.
    task automatic step();
        exp_t        e;
        logic        both;
        logic [31:0] d;
        logic [31:0] ea, ew;
        logic [3:0]  es;
        both = cpu_ce && dma_req;
        if (!both) begin
            e.gdma = dma_req;
        end else if (m_last == 2) begin
            e.gdma = (m_burst < 4);
        end else begin
            e.gdma = (m_wait >= 8);
        end
        e.gcpu = cpu_ce && !e.gdma;
        exp_q.push_back(e);
        if (e.gdma && !dma_we) rd_q.push_back(exp_mem[dma_addr[7:2]]);
        #7;
        e = exp_q.pop_front();
        ea = e.gdma ? dma_addr  : (e.gcpu ? cpu_addr  : 32'h0);
        ew = e.gdma ? dma_wdata : (e.gcpu ? cpu_wdata : 32'h0);
        es = e.gdma ? dma_sel   : (e.gcpu ? cpu_sel   : 4'h0);
        check_val("cpu_stall", {31'h0, cpu_stall}, {31'h0, cpu_ce && !e.gcpu});
        check_val("dma_gnt", {31'h0, dma_gnt}, {31'h0, e.gdma});
        check_val("ram_ce", {31'h0, ram_ce}, {31'h0, e.gcpu || e.gdma});
        check_val("ram_we", {31'h0, ram_we},
                  {31'h0, (e.gdma && dma_we) || (e.gcpu && cpu_we)});
        check_val("ram_addr", ram_addr, ea);
        check_val("ram_wdata", ram_wdata, ew);
        check_val("ram_sel", {28'h0, ram_sel}, {28'h0, es});
        if (e.gcpu && !cpu_we) check_val("cpu_rdata", cpu_rdata, exp_mem[cpu_addr[7:2]]);
        check_val("dma_rvld", {31'h0, dma_rvld}, {31'h0, exp_rvld});
        if (dma_rvld) begin
            if (rd_q.size() == 0) begin
                check_val("rd_q_empty", 32'h1, 32'h0);
            end else begin
                d = rd_q.pop_front();
                check_val("dma_rdata", dma_rdata, d);
            end
        end
        if (cpu_stall) cnt_dma_g += 0;
        if (dma_gnt) cnt_dma_g++;
        if (ram_ce && !dma_gnt) cnt_cpu_g++;
        // Model state update and shadow memory write.
        if (e.gdma && dma_we)
            for (int b = 0; b < 4; b++)
                if (dma_sel[b]) exp_mem[dma_addr[7:2]][b*8 +: 8] = dma_wdata[b*8 +: 8];
        if (e.gcpu && cpu_we)
            for (int b = 0; b < 4; b++)
                if (cpu_sel[b]) exp_mem[cpu_addr[7:2]][b*8 +: 8] = cpu_wdata[b*8 +: 8];
        m_last  = e.gdma ? 2 : (e.gcpu ? 1 : 0);
        m_burst = e.gdma ? ((m_burst < 4) ? m_burst + 1 : 4) : 0;
        m_wait  = (e.gdma || !dma_req) ? 0 : ((m_wait < 8) ? m_wait + 1 : 8);
        exp_rvld = e.gdma && !dma_we;
        dma_pend = dma_req && !e.gdma;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic ce, input logic we, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] wd);
        cpu_ce = ce; cpu_we = we; cpu_addr = a; cpu_sel = s; cpu_wdata = wd;
    endtask

    task automatic set_dma(input logic rq, input logic we, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] wd);
        dma_req = rq; dma_we = we; dma_addr = a; dma_sel = s; dma_wdata = wd;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cnt_cpu_g = 0; cnt_dma_g = 0;
        for (int i = 0; i < 64; i++) exp_mem[i] = 32'h0;
        model_reset();
        rst = 1'b1; init_mem = 1'b1;
        set_cpu(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        set_dma(1'b1, 1'b1, 32'h4, 4'hF, 32'h1234_5678);
        repeat (3) @(posedge clk);
        #2;
        // Reset state: all grants forced off even with both requesting.
        check_val("rst_ram_ce", {31'h0, ram_ce}, 32'h0);
        check_val("rst_ram_we", {31'h0, ram_we}, 32'h0);
        check_val("rst_stall", {31'h0, cpu_stall}, 32'h0);
        check_val("rst_gnt", {31'h0, dma_gnt}, 32'h0);
        check_val("rst_rvld", {31'h0, dma_rvld}, 32'h0);
        check_val("rst_rdata", dma_rdata, 32'h0);
        set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_dma(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0; init_mem = 1'b0;
        @(posedge clk); #1;

        // 1: CPU only write then read.
        set_cpu(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF); step();
        set_cpu(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);         step();
        check_val("s1_rdata", cpu_rdata, 32'hDEAD_BEEF);
        set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // 2: DMA only read; data returns one cycle later.
        set_dma(1'b1, 1'b0, 32'h10, 4'hF, 32'h0); step();
        check_val("s2_rvld", {31'h0, dma_rvld}, 32'h1);
        check_val("s2_rdata", dma_rdata, 32'hDEAD_BEEF);
        set_dma(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); step();
        check_val("s2_rvld_low", {31'h0, dma_rvld}, 32'h0);

        // 3: both held 20 cycles -> CPU 8, DMA 4, CPU 8.
        cnt_cpu_g = 0; cnt_dma_g = 0;
        set_cpu(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        set_dma(1'b1, 1'b0, 32'h24, 4'hF, 32'h0);
        for (int i = 0; i < 20; i++) step();
        check_val("s3_cpu_grants", cnt_cpu_g, 32'd16);
        check_val("s3_dma_grants", cnt_dma_g, 32'd4);
`ifdef ARB_STAT_EN
        check_val("s6_cpu_stall_cnt", cpu_stall_cnt, 32'd4);
        check_val("s6_dma_stall_cnt", dma_stall_cnt, 32'd16);
`endif
        set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_dma(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); step();

        // 4: DMA burst, CPU joins mid-burst -> DMA finishes its cap then yields.
        set_dma(1'b1, 1'b1, 32'h40, 4'hF, 32'hA5A5_0001); step();
        set_dma(1'b1, 1'b1, 32'h44, 4'h3, 32'hA5A5_0002); step();
        cnt_cpu_g = 0; cnt_dma_g = 0;
        set_cpu(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
        for (int i = 0; i < 6; i++) step();
        check_val("s4_dma_while_cpu", cnt_dma_g, 32'd2);
        check_val("s4_cpu_grants", cnt_cpu_g, 32'd4);
        set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_dma(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); step();

        // Random traffic; DMA keeps its request and fields until granted.
        for (int i = 0; i < 300; i++) begin
            set_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                    4'($urandom_range(1, 15)), $urandom);
            if (!dma_pend)
                set_dma(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                        4'($urandom_range(1, 15)), $urandom);
            step();
        end
        set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_dma(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); step();

        // 5: reset pulsed during a DMA burst; pending read valid is dropped.
        set_dma(1'b1, 1'b1, 32'h80, 4'hF, 32'h1111_1111); step();
        set_dma(1'b1, 1'b0, 32'h80, 4'hF, 32'h0);         step();
        set_dma(1'b1, 1'b1, 32'h84, 4'hF, 32'h5555_5555);
        #2;
        rst = 1'b1;
        #1;
        check_val("s5_ram_ce", {31'h0, ram_ce}, 32'h0);
        check_val("s5_ram_we", {31'h0, ram_we}, 32'h0);
        check_val("s5_gnt", {31'h0, dma_gnt}, 32'h0);
        check_val("s5_rvld", {31'h0, dma_rvld}, 32'h0);
        check_val("s5_rdata", dma_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_val("s5_no_write", mem[6'h21], exp_mem[6'h21]);
        set_dma(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        set_cpu(1'b1, 1'b0, 32'h80, 4'hF, 32'h0); step();
        check_val("s5_cpu_after", cpu_rdata, 32'h1111_1111);
        set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
